psum_output_packer: RTL and testbench

Downstream of the psum accumulator: takes the four per-kernel accumulated psum streams, applies an optional per-kernel ReLU, and packs four consecutive results of each kernel into one 32-bit word. It arbitrates the four kernel lanes round-robin onto a single valid/ready output port feeding the output-feature-map write path.

---
 rtl/psum_output_packer_if.sv | 40 ++++
 rtl/psum_output_packer.sv | 156 +++++++++++++++
 tb/tb_psum_output_packer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/psum_output_packer_if.sv
// Bundle between the psum accumulator, the output packer and the OFM write path.
// The packer uses the slave modport; the upstream/bench side uses master.
interface psum_output_packer_if #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int OUT_WIDTH  = 32
);
    logic [NUM_KERNEL-1:0] i_conf_relu;
    logic                  i_flush;
    logic [BIT_WIDTH-1:0]  i_psum_kn0;
    logic [BIT_WIDTH-1:0]  i_psum_kn1;
    logic [BIT_WIDTH-1:0]  i_psum_kn2;
    logic [BIT_WIDTH-1:0]  i_psum_kn3;
    logic                  i_psum_kn0_val;
    logic                  i_psum_kn1_val;
    logic                  i_psum_kn2_val;
    logic                  i_psum_kn3_val;
    logic [OUT_WIDTH-1:0]  o_data;
    logic [1:0]            o_data_kn;
    logic                  o_data_val;
    logic                  i_data_rdy;
    logic                  o_err_ovf;
    logic                  o_busy;

    modport master (
        output i_conf_relu, i_flush,
        output i_psum_kn0, i_psum_kn1, i_psum_kn2, i_psum_kn3,
        output i_psum_kn0_val, i_psum_kn1_val, i_psum_kn2_val, i_psum_kn3_val,
        output i_data_rdy,
        input  o_data, o_data_kn, o_data_val, o_err_ovf, o_busy
    );

    modport slave (
        input  i_conf_relu, i_flush,
        input  i_psum_kn0, i_psum_kn1, i_psum_kn2, i_psum_kn3,
        input  i_psum_kn0_val, i_psum_kn1_val, i_psum_kn2_val, i_psum_kn3_val,
        input  i_data_rdy,
        output o_data, o_data_kn, o_data_val, o_err_ovf, o_busy
    );
endinterface

// File: rtl/psum_output_packer.sv
// Per-kernel ReLU + byte packing into 32-bit words, with round-robin
// arbitration of the four lane hold registers onto one valid/ready port.
module psum_packer_lane #(
    parameter int BIT_WIDTH = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] psum,
    input  logic                 psum_val,
    input  logic                 relu,
    input  logic                 flush,
    input  logic                 drain,
    output logic [OUT_WIDTH-1:0] hold,
    output logic                 hold_val,
    output logic                 pending,
    output logic                 ovf
);
    localparam int PACK_W = OUT_WIDTH - BIT_WIDTH;

    logic [PACK_W-1:0]    pack, pack_nxt;
    logic [1:0]           cnt, cnt_nxt;
    logic [BIT_WIDTH-1:0] byte_in;
    logic [OUT_WIDTH-1:0] word;
    logic                 done;

    always_comb begin
        byte_in  = (relu && psum[BIT_WIDTH-1]) ? '0 : psum;
        pack_nxt = pack;
        cnt_nxt  = cnt;
        word     = '0;
        done     = 1'b0;
        if (psum_val) begin
            if (cnt == 2'd3) begin
                word = {byte_in, pack};
                done = 1'b1;
            end else begin
                for (int i = 0; i < 3; i++)
                    if (cnt == 2'(i)) pack_nxt[i*BIT_WIDTH +: BIT_WIDTH] = byte_in;
                cnt_nxt = cnt + 2'd1;
            end
        end
        // A flush that lands with the 4th byte is already a full word, so only
        // partial words are padded here; unused pack bytes are always zero.
        if (flush && !done && cnt_nxt != 2'd0) begin
            word = {{BIT_WIDTH{1'b0}}, pack_nxt};
            done = 1'b1;
        end
    end

    assign ovf     = done && hold_val && !drain;
    assign pending = (cnt != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack     <= '0;
            cnt      <= '0;
            hold     <= '0;
            hold_val <= 1'b0;
        end else if (done) begin
            pack <= '0;
            cnt  <= '0;
            // Occupied, undrained hold keeps the older word; the new one is lost.
            if (!hold_val || drain) begin
                hold     <= word;
                hold_val <= 1'b1;
            end
        end else begin
            pack <= pack_nxt;
            cnt  <= cnt_nxt;
            if (drain) hold_val <= 1'b0;
        end
    end
endmodule

module psum_output_packer #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    psum_output_packer_if.slave  bus
);
    logic [NUM_KERNEL-1:0][BIT_WIDTH-1:0] psum;
    logic [NUM_KERNEL-1:0]                psum_val;
    logic [NUM_KERNEL-1:0][OUT_WIDTH-1:0] hold;
    logic [NUM_KERNEL-1:0]                hold_val, pending, ovf, drain;
    logic [1:0]                           rr_ptr, grant, idx;
    logic                                 grant_ok, load;

    assign psum     = {bus.i_psum_kn3, bus.i_psum_kn2, bus.i_psum_kn1, bus.i_psum_kn0};
    assign psum_val = {bus.i_psum_kn3_val, bus.i_psum_kn2_val,
                       bus.i_psum_kn1_val, bus.i_psum_kn0_val};

    for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
        psum_packer_lane #(.BIT_WIDTH(BIT_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .psum     (psum[k]),
            .psum_val (psum_val[k]),
            .relu     (bus.i_conf_relu[k]),
            .flush    (bus.i_flush),
            .drain    (drain[k]),
            .hold     (hold[k]),
            .hold_val (hold_val[k]),
            .pending  (pending[k]),
            .ovf      (ovf[k])
        );
    end

    assign load = !bus.o_data_val || bus.i_data_rdy;

    // Search starts one past the last grant; i==4 wraps back to rr_ptr itself.
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        idx      = '0;
        for (int i = 1; i <= NUM_KERNEL; i++) begin
            idx = rr_ptr + 2'(i);
            if (!grant_ok && hold_val[idx]) begin
                grant    = idx;
                grant_ok = 1'b1;
            end
        end
    end

    always_comb begin
        drain = '0;
        if (load && grant_ok) drain[grant] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.o_data     <= '0;
            bus.o_data_kn  <= '0;
            bus.o_data_val <= 1'b0;
            bus.o_err_ovf  <= 1'b0;
            rr_ptr         <= 2'd3;
        end else begin
            if (load) begin
                if (grant_ok) begin
                    bus.o_data     <= hold[grant];
                    bus.o_data_kn  <= grant;
                    bus.o_data_val <= 1'b1;
                    rr_ptr         <= grant;
                end else begin
                    bus.o_data_val <= 1'b0;
                end
            end
            if (|ovf) bus.o_err_ovf <= 1'b1;
        end
    end

    assign bus.o_busy = (|pending) || (|hold_val) || bus.o_data_val;
endmodule

// File: tb/tb_psum_output_packer.sv
// Self-checking bench: vector table for packing/ReLU, hand sequences for
// round-robin, flush, overflow/stall and mid-operation reset.
module tb_psum_output_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    psum_output_packer_if bus ();
    psum_output_packer dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  kn;
    } exp_t;

    typedef struct {
        int              lane;
        logic            relu;
        logic [3:0][7:0] b;
        logic [31:0]     exp;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && bus.o_data_val && bus.i_data_rdy) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got %h kn %0d, expected none", bus.o_data, bus.o_data_kn);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_data", bus.o_data, e.data);
                chk("sb_kn", 32'(bus.o_data_kn), 32'(e.kn));
            end
        end
    end

    task automatic step(input logic [3:0] v, input logic [3:0][7:0] b, input logic fl);
        bus.i_psum_kn0 = b[0]; bus.i_psum_kn1 = b[1];
        bus.i_psum_kn2 = b[2]; bus.i_psum_kn3 = b[3];
        bus.i_psum_kn0_val = v[0]; bus.i_psum_kn1_val = v[1];
        bus.i_psum_kn2_val = v[2]; bus.i_psum_kn3_val = v[3];
        bus.i_flush = fl;
        @(posedge clk); #1;
        {bus.i_psum_kn3_val, bus.i_psum_kn2_val, bus.i_psum_kn1_val, bus.i_psum_kn0_val} = 4'b0;
        bus.i_flush = 1'b0;
    endtask

    task automatic feed(input int lane, input logic [7:0] d, input logic fl);
        logic [3:0][7:0] b;
        logic [3:0]      v;
        b = '0; v = '0;
        b[lane] = d; v[lane] = 1'b1;
        step(v, b, fl);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    vec_t vec[6];

    initial begin
        bus.i_conf_relu = '0;
        bus.i_flush = 1'b0;
        bus.i_data_rdy = 1'b1;
        {bus.i_psum_kn0, bus.i_psum_kn1, bus.i_psum_kn2, bus.i_psum_kn3} = '0;
        {bus.i_psum_kn3_val, bus.i_psum_kn2_val, bus.i_psum_kn1_val, bus.i_psum_kn0_val} = 4'b0;

        vec[0] = '{0, 1'b0, {8'h44, 8'h33, 8'h22, 8'h11}, 32'h44332211};
        vec[1] = '{2, 1'b1, {8'h7F, 8'hFF, 8'h05, 8'h80}, 32'h7F000500};
        vec[2] = '{2, 1'b0, {8'h7F, 8'hFF, 8'h05, 8'h80}, 32'h7FFF0580};
        vec[3] = '{1, 1'b1, {8'h04, 8'h03, 8'h02, 8'h01}, 32'h04030201};
        vec[4] = '{3, 1'b1, {8'h80, 8'h81, 8'hFE, 8'hFF}, 32'h00000000};
        vec[5] = '{3, 1'b0, {8'h80, 8'h81, 8'hFE, 8'hFF}, 32'h8081FEFF};

        idle(3);
        chk("rst_data", bus.o_data, 32'h0);
        chk("rst_kn", 32'(bus.o_data_kn), 32'h0);
        chk("rst_val", 32'(bus.o_data_val), 32'h0);
        chk("rst_ovf", 32'(bus.o_err_ovf), 32'h0);
        chk("rst_busy", 32'(bus.o_busy), 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Single-lane words, latency and single-cycle valid
        for (int i = 0; i < 6; i++) begin
            bus.i_conf_relu = '0;
            bus.i_conf_relu[vec[i].lane] = vec[i].relu;
            sb.push_back({vec[i].exp, 2'(vec[i].lane)});
            for (int j = 0; j < 4; j++) feed(vec[i].lane, vec[i].b[j], 1'b0);
            chk("lat_t1_val", 32'(bus.o_data_val), 32'h0);
            idle(1);
            chk("lat_t2_val", 32'(bus.o_data_val), 32'h1);
            idle(1);
            chk("one_cycle_val", 32'(bus.o_data_val), 32'h0);
        end

        // All lanes, two back-to-back batches: order 0,1,2,3 each batch
        bus.i_conf_relu = '0;
        for (int bt = 0; bt < 2; bt++)
            for (int k = 0; k < 4; k++) begin
                int base;
                base = (k << 4) + (bt << 6);
                sb.push_back({{8'(base + 4), 8'(base + 3), 8'(base + 2), 8'(base + 1)}, 2'(k)});
            end
        for (int bt = 0; bt < 2; bt++)
            for (int j = 0; j < 4; j++) begin
                logic [3:0][7:0] b;
                for (int k = 0; k < 4; k++) b[k] = 8'((k << 4) + (bt << 6) + j + 1);
                step(4'hF, b, 1'b0);
            end
        idle(6);
        chk("rr_drained", 32'(sb.size()), 32'h0);

        // Flush of a partial word, then flush with nothing pending
        feed(1, 8'hAA, 1'b0);
        chk("busy_partial", 32'(bus.o_busy), 32'h1);
        feed(1, 8'hBB, 1'b0);
        sb.push_back({32'h0000BBAA, 2'd1});
        step(4'h0, '0, 1'b1);
        idle(4);
        chk("busy_after_flush", 32'(bus.o_busy), 32'h0);
        step(4'h0, '0, 1'b1);
        for (int n = 0; n < 3; n++) begin
            chk("empty_flush_busy", 32'(bus.o_busy), 32'h0);
            chk("empty_flush_val", 32'(bus.o_data_val), 32'h0);
            idle(1);
        end

        // Flush coinciding with 4th byte, and with a 2nd byte
        sb.push_back({32'h04030201, 2'd0});
        feed(0, 8'h01, 1'b0); feed(0, 8'h02, 1'b0); feed(0, 8'h03, 1'b0);
        feed(0, 8'h04, 1'b1);
        sb.push_back({32'h00003412, 2'd2});
        feed(2, 8'h12, 1'b0);
        feed(2, 8'h34, 1'b1);
        idle(5);
        chk("flush_drained", 32'(sb.size()), 32'h0);

        // Overflow under backpressure
        bus.i_data_rdy = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            feed(3, 8'(n), 1'b0);
            if (n == 8) chk("ovf_before", 32'(bus.o_err_ovf), 32'h0);
        end
        chk("ovf_set", 32'(bus.o_err_ovf), 32'h1);
        for (int n = 0; n < 3; n++) begin
            chk("stall_val", 32'(bus.o_data_val), 32'h1);
            chk("stall_data", bus.o_data, 32'h04030201);
            chk("stall_kn", 32'(bus.o_data_kn), 32'h3);
            idle(1);
        end
        sb.push_back({32'h04030201, 2'd3});
        sb.push_back({32'h08070605, 2'd3});
        bus.i_data_rdy = 1'b1;
        idle(5);
        chk("ovf_sticky", 32'(bus.o_err_ovf), 32'h1);
        chk("ovf_drained", 32'(sb.size()), 32'h0);

        // Reset mid-operation: pending output word and partial lane 0
        bus.i_data_rdy = 1'b0;
        for (int n = 0; n < 4; n++) feed(1, 8'(8'h21 + n), 1'b0);
        idle(2);
        feed(0, 8'hAA, 1'b0);
        feed(0, 8'hBB, 1'b0);
        chk("pre_rst_val", 32'(bus.o_data_val), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_data", bus.o_data, 32'h0);
        chk("arst_kn", 32'(bus.o_data_kn), 32'h0);
        chk("arst_val", 32'(bus.o_data_val), 32'h0);
        chk("arst_ovf", 32'(bus.o_err_ovf), 32'h0);
        chk("arst_busy", 32'(bus.o_busy), 32'h0);
        @(negedge clk) rst = 1'b0;
        bus.i_data_rdy = 1'b1;
        @(posedge clk); #1;
        sb.push_back({32'h88776655, 2'd0});
        feed(0, 8'h55, 1'b0); feed(0, 8'h66, 1'b0);
        feed(0, 8'h77, 1'b0); feed(0, 8'h88, 1'b0);

        for (int n = 0; n < 20 && sb.size() != 0; n++) idle(1);
        idle(3);
        chk("final_sb_empty", 32'(sb.size()), 32'h0);
        chk("final_busy", 32'(bus.o_busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
